// File: rtl/instr_fetch_mem_pkg.sv
// Shared types and default constants for the instruction fetch memory.
// Parity option is selected in the top via INSTR_FETCH_MEM_PARITY_EN.
package instr_fetch_mem_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fetch_state_t;

  localparam int DEF_DATA_W    = 32;
  localparam int DEF_ADDR_W    = 10;
  localparam int DEF_DEPTH     = 128;
  localparam int DEF_NUM_PROG  = 4;
  localparam int DEF_SLOT_SIZE = 32;

  // Zero word returned for out-of-slot fetches.
  localparam logic [DEF_DATA_W-1:0] NOP = '0;

  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/instr_fetch_ram.sv
// Single-clock synchronous RAM, one read and one write port, read-first.
module instr_fetch_ram #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 128,
  parameter int IDX_W = 7
) (
  input  logic             clock,
  input  logic             rd_en,
  input  logic [IDX_W-1:0] rd_addr,
  output logic [WIDTH-1:0] rd_data,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_addr,
  input  logic [WIDTH-1:0] wr_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Read and write share one edge; the read samples the pre-write contents.
  always_ff @(posedge clock) begin
    if (rd_en) rd_data <= mem[rd_addr];
    if (wr_en) mem[wr_addr] <= wr_data;
  end

endmodule

// File: rtl/instr_fetch_mem.sv
// Program-slot instruction fetch memory with loader port and IDLE/RUN control.
// Define INSTR_FETCH_MEM_PARITY_EN to add per-word even parity and parity_err.
module instr_fetch_mem
  import instr_fetch_mem_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int NUM_PROG   = DEF_NUM_PROG,
  parameter int SLOT_SIZE  = DEF_SLOT_SIZE,
  parameter int PROG_SEL_W = (NUM_PROG > 1) ? $clog2(NUM_PROG) : 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [PROG_SEL_W-1:0] prog_sel,
  input  logic                  start,
  input  logic                  halt,
  input  logic                  fetch_req,
  input  logic [ADDR_W-1:0]     address,
  input  logic                  load_en,
  input  logic [ADDR_W-1:0]     load_addr,
  input  logic [DATA_W-1:0]     load_data,
  output logic [DATA_W-1:0]     instrucao,
  output logic                  instr_valid,
  output logic                  running,
  output logic                  addr_err,
`ifdef INSTR_FETCH_MEM_PARITY_EN
  output logic                  parity_err,
`endif
  output logic                  load_err
);

  localparam int IDX_W = idx_width(DEPTH);
`ifdef INSTR_FETCH_MEM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  fetch_state_t      state;
  logic [ADDR_W-1:0] base;
  logic              nop_sel;
  logic              fetch_ok;
  logic              in_slot;
  logic              load_ok;
  logic              rd_en;
  logic              wr_en;
  logic [ADDR_W-1:0] rd_addr_full;
  logic [ADDR_W-1:0] slot_base;
  logic [MEM_W-1:0]  ram_q;
  logic [MEM_W-1:0]  wr_word;
  logic              unused_addr_bits;

  assign fetch_ok     = (state == RUN) && fetch_req;
  assign in_slot      = 32'(address) < SLOT_SIZE;
  assign load_ok      = (state == IDLE) && (32'(load_addr) < DEPTH);
  assign rd_en        = fetch_ok && in_slot && !reset;
  assign wr_en        = load_en && load_ok;
  assign rd_addr_full = base + address;
  assign slot_base    = ADDR_W'(32'(prog_sel) * SLOT_SIZE);
  assign unused_addr_bits = ^rd_addr_full;

`ifdef INSTR_FETCH_MEM_PARITY_EN
  assign wr_word = {^load_data, load_data};
`else
  assign wr_word = load_data;
`endif

  instr_fetch_ram #(
    .WIDTH (MEM_W),
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_ram (
    .clock   (clock),
    .rd_en   (rd_en),
    .rd_addr (rd_addr_full[IDX_W-1:0]),
    .rd_data (ram_q),
    .wr_en   (wr_en),
    .wr_addr (load_addr[IDX_W-1:0]),
    .wr_data (wr_word)
  );

  // The RAM register only updates on in-slot fetches and nop_sel only on
  // accepted fetches, so instrucao holds between instr_valid pulses.
  assign instrucao = nop_sel ? DATA_W'(NOP) : ram_q[DATA_W-1:0];

`ifdef INSTR_FETCH_MEM_PARITY_EN
  assign parity_err = instr_valid && !nop_sel && (^ram_q);
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      base        <= '0;
      nop_sel     <= 1'b1;
      instr_valid <= 1'b0;
      running     <= 1'b0;
      addr_err    <= 1'b0;
      load_err    <= 1'b0;
    end else begin
      instr_valid <= fetch_ok;
      addr_err    <= fetch_ok && !in_slot;
      load_err    <= load_en && !load_ok;
      if (fetch_ok) nop_sel <= !in_slot;
      case (state)
        IDLE: begin
          if (start && !halt) begin
            state   <= RUN;
            running <= 1'b1;
            base    <= slot_base;
          end
        end
        RUN: begin
          if (halt) begin
            state   <= IDLE;
            running <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          running <= 1'b0;
        end
      endcase
    end
  end

endmodule
